// File: rtl/bitwise_lu_seq_if.sv
// ---------------------------------------------------------------------------
// bitwise_lu_seq_if
// Operand/result bundle for the sequential bitwise logic unit.
//
//   start   master->slave  request; sampled by the unit only while idle
//   op      master->slave  00 AND, 01 OR, 10 XOR, 11 XNOR
//   A, B    master->slave  operands, WIDTH bits
//   F       slave->master  result register, WIDTH bits
//   busy    slave->master  operation in progress
//   done    slave->master  one-cycle completion pulse
//   zero    slave->master  F == 0
//   parity  slave->master  XOR-reduction of F
//
// Handshake: a request is taken on a rising edge where start=1 and busy=0.
// The unit then keeps busy=1 for WIDTH/LANE cycles. busy drops in the same
// edge that raises done. A start presented while done=1 is accepted on the
// next edge, so consecutive operations run with no gap. start seen while
// busy=1 is dropped, not queued.
// ---------------------------------------------------------------------------
interface bitwise_lu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] F;
    logic             busy;
    logic             done;
    logic             zero;
    logic             parity;

    modport master (
        output start, op, A, B,
        input  F, busy, done, zero, parity
    );

    modport slave (
        input  start, op, A, B,
        output F, busy, done, zero, parity
    );
endinterface

// File: rtl/bitwise_lu_seq.sv
// ---------------------------------------------------------------------------
// bitwise_lu_seq
// Sequential AND/OR/XOR/XNOR unit. Operands are latched when a start is
// accepted. The unit then processes LANE bits per cycle, least-significant
// lane first. F, zero and parity are written together in the cycle that
// finishes the last lane, so partial results are never visible.
//
// Parameters: WIDTH (operand width, a multiple of LANE), LANE (bits/cycle)
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      slave side of bitwise_lu_seq_if (start/op/A/B in, F/flags out)
//   state_o  debug view of the FSM: 0 = IDLE, 1 = RUN
// ---------------------------------------------------------------------------
module bitwise_lu_seq #(
    parameter int WIDTH = 8,
    parameter int LANE  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    bitwise_lu_seq_if.slave   bus,
    output logic              state_o
);
    localparam int N  = WIDTH / LANE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, f_q;
    logic [1:0]       op_q;
    logic [IW-1:0]    idx_q;
    logic             done_q, zero_q, parity_q;

    logic [LANE-1:0]  a_lane, b_lane, lane_res;
    logic [WIDTH-1:0] acc_d;
    logic             last_lane;

    // Operate on the current lane and merge it into a copy of the
    // accumulator. On the last lane, acc_d is the complete result, and it is
    // what F and the flags take.
    always_comb begin
        a_lane = a_q[int'(idx_q)*LANE +: LANE];
        b_lane = b_q[int'(idx_q)*LANE +: LANE];
        case (op_q)
            2'b00:   lane_res = a_lane & b_lane;
            2'b01:   lane_res = a_lane | b_lane;
            2'b10:   lane_res = a_lane ^ b_lane;
            default: lane_res = ~(a_lane ^ b_lane);
        endcase
        acc_d = acc_q;
        acc_d[int'(idx_q)*LANE +: LANE] = lane_res;
        last_lane = (idx_q == IW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'b00;
            acc_q    <= '0;
            idx_q    <= '0;
            f_q      <= '0;
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // done is a single-cycle pulse. It always falls in the
                    // first IDLE cycle, even when a new start is taken here.
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        op_q    <= bus.op;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    if (last_lane) begin
                        f_q      <= acc_d;
                        zero_q   <= (acc_d == '0);
                        parity_q <= ^acc_d;
                        done_q   <= 1'b1;
                        idx_q    <= '0;
                        state_q  <= S_IDLE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.F      = f_q;
    assign bus.busy   = (state_q == S_RUN);
    assign bus.done   = done_q;
    assign bus.zero   = zero_q;
    assign bus.parity = parity_q;
    assign state_o    = state_q;
endmodule

// File: tb/tb_bitwise_lu_seq.sv
// ---------------------------------------------------------------------------
// tb_bitwise_lu_seq
// Bench for bitwise_lu_seq. It builds three instances:
//   d0: WIDTH=8,  LANE=2
//   d1: WIDTH=16, LANE=4
//   d2: WIDTH=8,  LANE=8
// Expected results come from a whole-word reference model.
// ---------------------------------------------------------------------------
module tb_bitwise_lu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st0, st1, st2;

  always #5 clk = ~clk;

  bitwise_lu_seq_if #(.WIDTH(8))  if0 ();
  bitwise_lu_seq_if #(.WIDTH(16)) if1 ();
  bitwise_lu_seq_if #(.WIDTH(8))  if2 ();

  bitwise_lu_seq #(.WIDTH(8),  .LANE(2)) d0 (.clk(clk), .rst_n(rst_n), .bus(if0), .state_o(st0));
  bitwise_lu_seq #(.WIDTH(16), .LANE(4)) d1 (.clk(clk), .rst_n(rst_n), .bus(if1), .state_o(st1));
  bitwise_lu_seq #(.WIDTH(8),  .LANE(8)) d2 (.clk(clk), .rst_n(rst_n), .bus(if2), .state_o(st2));

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole-word reference model.
  function automatic logic [15:0] model(input int w, input logic [1:0] op,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [15:0] mask;
    mask = 16'((32'd1 << w) - 1);
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~(a ^ b);
    endcase
    return r & mask;
  endfunction

  function automatic logic model_par(input logic [15:0] f);
    int ones;
    ones = 0;
    for (int i = 0; i < 16; i++) if (f[i]) ones++;
    return logic'(ones % 2);
  endfunction

  // done and busy must never be high together on any instance.
  always @(negedge clk) begin
    check("d0_done_busy", {31'd0, if0.done & if0.busy}, 32'd0);
    check("d1_done_busy", {31'd0, if1.done & if1.busy}, 32'd0);
    check("d2_done_busy", {31'd0, if2.done & if2.busy}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on d0. The task is called #1 after an edge. If the
  // previous call ended in d0's done cycle, this start is back-to-back.
  task automatic run_op0(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0]  f_before;
    logic [15:0] e;
    int lat;
    f_before = if0.F;
    if0.start = 1'b1;
    if0.op = op;
    if0.A = a;
    if0.B = b;
    exp_q.push_back(model(8, op, {8'd0, a}, {8'd0, b}));
    tick();
    if0.start = 1'b0;
    check("d0_busy_after_accept", {31'd0, if0.busy}, 32'd1);
    check("d0_done_one_cycle", {31'd0, if0.done}, 32'd0);
    lat = 0;
    while (!if0.done && lat < 16) begin
      check("d0_F_hold_busy", {24'd0, if0.F}, {24'd0, f_before});
      tick();
      lat++;
    end
    check("d0_latency", lat, 32'd4);
    e = exp_q.pop_front();
    check("d0_F", {24'd0, if0.F}, {16'd0, e});
    check("d0_zero", {31'd0, if0.zero}, {31'd0, e == 16'd0});
    check("d0_parity", {31'd0, if0.parity}, {31'd0, model_par(e)});
    check("d0_busy_at_done", {31'd0, if0.busy}, 32'd0);
  endtask

  // One operation in parallel on d1 (16/4) and d2 (8/8).
  task automatic run_all(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] e1, e2;
    int lat1, lat2, cyc;
    e1 = model(16, op, a, b);
    e2 = model(8, op, a, b);
    if1.start = 1'b1; if1.op = op; if1.A = a; if1.B = b;
    if2.start = 1'b1; if2.op = op; if2.A = a[7:0]; if2.B = b[7:0];
    tick();
    if1.start = 1'b0;
    if2.start = 1'b0;
    lat1 = -1;
    lat2 = -1;
    cyc = 0;
    while ((lat1 < 0 || lat2 < 0) && cyc < 16) begin
      tick();
      cyc++;
      if (if1.done && lat1 < 0) begin
        lat1 = cyc;
        check("d1_F", {16'd0, if1.F}, {16'd0, e1});
        check("d1_zero", {31'd0, if1.zero}, {31'd0, e1 == 16'd0});
        check("d1_parity", {31'd0, if1.parity}, {31'd0, model_par(e1)});
      end
      if (if2.done && lat2 < 0) begin
        lat2 = cyc;
        check("d2_F", {24'd0, if2.F}, {16'd0, e2});
        check("d2_zero", {31'd0, if2.zero}, {31'd0, e2 == 16'd0});
        check("d2_parity", {31'd0, if2.parity}, {31'd0, model_par(e2)});
      end
    end
    check("d1_latency", lat1, 32'd4);
    check("d2_latency", lat2, 32'd1);
  endtask

  initial begin
    int dones;
    if0.start = 1'b0; if0.op = 2'b00; if0.A = '0; if0.B = '0;
    if1.start = 1'b0; if1.op = 2'b00; if1.A = '0; if1.B = '0;
    if2.start = 1'b0; if2.op = 2'b00; if2.A = '0; if2.B = '0;

    // Reset held while start pulses.
    rst_n = 1'b0;
    #2;
    if0.start = 1'b1;
    tick();
    tick();
    if0.start = 1'b0;
    check("rst_F", {24'd0, if0.F}, 32'd0);
    check("rst_zero", {31'd0, if0.zero}, 32'd1);
    check("rst_parity", {31'd0, if0.parity}, 32'd0);
    check("rst_busy", {31'd0, if0.busy}, 32'd0);
    check("rst_done", {31'd0, if0.done}, 32'd0);
    check("rst_d1_zero", {31'd0, if1.zero}, 32'd1);
    rst_n = 1'b1;

    // The first edge after release accepts start.
    run_op0(2'b10, 8'h00, 8'hFF);
    check("xor_00_FF", {24'd0, if0.F}, 32'h0000_00FF);
    tick();
    run_op0(2'b10, 8'hAA, 8'h55);
    check("xor_AA_55", {24'd0, if0.F}, 32'h0000_00FF);

    // All four ops run back-to-back, each started in the previous done cycle.
    tick();
    run_op0(2'b00, 8'hF0, 8'h0F);
    check("and_F0_0F", {24'd0, if0.F}, 32'h0000_0000);
    run_op0(2'b01, 8'hF0, 8'h0F);
    check("or_F0_0F", {24'd0, if0.F}, 32'h0000_00FF);
    run_op0(2'b10, 8'hF0, 8'h0F);
    check("xor_F0_0F", {24'd0, if0.F}, 32'h0000_00FF);
    run_op0(2'b11, 8'hF0, 8'h0F);
    check("xnor_F0_0F", {24'd0, if0.F}, 32'h0000_0000);
    check("xnor_F0_0F_zero", {31'd0, if0.zero}, 32'd1);

    // Inputs change and start pulses mid-RUN.
    tick();
    if0.start = 1'b1; if0.op = 2'b11; if0.A = 8'hFF; if0.B = 8'hFF;
    tick();
    if0.start = 1'b0;
    tick();
    if0.A = 8'h00; if0.B = 8'h00; if0.op = 2'b00; if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (if0.done) begin
        dones++;
        check("hazard_F", {24'd0, if0.F}, 32'h0000_00FF);
      end
      tick();
    end
    check("hazard_done_count", dones, 32'd1);
    check("hazard_idle", {31'd0, if0.busy}, 32'd0);

    // Reset asserted two cycles into an operation.
    run_op0(2'b10, 8'hAA, 8'h55);
    tick();
    if0.start = 1'b1; if0.op = 2'b01; if0.A = 8'h0F; if0.B = 8'hF0;
    tick();
    if0.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_F", {24'd0, if0.F}, 32'd0);
    check("abort_busy", {31'd0, if0.busy}, 32'd0);
    check("abort_done", {31'd0, if0.done}, 32'd0);
    check("abort_zero", {31'd0, if0.zero}, 32'd1);
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (if0.done) dones++;
      tick();
    end
    check("abort_no_done", dones, 32'd0);
    run_op0(2'b01, 8'h0F, 8'hF0);
    check("after_abort_F", {24'd0, if0.F}, 32'h0000_00FF);

    // Parametrised instances.
    tick();
    run_all(2'b10, 16'h1234, 16'h00FF);
    check("d1_12CB", {16'd0, if1.F}, 32'h0000_12CB);
    check("d1_12CB_par", {31'd0, if1.parity}, 32'd1);
    tick();
    run_all(2'b00, 16'hF0F0, 16'h0F0F);
    check("d2_and_zero", {31'd0, if2.zero}, 32'd1);

    // Random stimulus. A zero gap exercises back-to-back issue.
    for (int i = 0; i < 24; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      run_op0(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      run_all(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
